// File: rtl/data_ram_pkg.sv
// Shared constants and address helper for the RV32IM data memory.
package data_ram_pkg;

  localparam int WORD_W        = 32;
  localparam int DEFAULT_DEPTH = 256;

  // Word index field of a byte address: drop lsb offset bits, keep idx_w bits.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input int          lsb,
                                             input int          idx_w);
    logic [31:0] mask;
    mask = (32'h1 << idx_w) - 32'h1;
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/rv_data_ram.sv
// Word-addressed data memory: synchronous write, combinational read, async clear.
// Optional macro DATA_RAM_BOUNDS_CHECK_EN rejects addresses above the index field.
module rv_data_ram
  import data_ram_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_LSB = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [31:0]       idx_full;
  logic [IDX_W-1:0]  idx;
  logic              in_range;

  assign idx_full = word_index(addr, ADDR_LSB, IDX_W);
  assign idx      = idx_full[IDX_W-1:0];

`ifdef DATA_RAM_BOUNDS_CHECK_EN
  assign in_range = ((addr >> (ADDR_LSB + IDX_W)) == 32'h0);
  logic unused_bits;
  assign unused_bits = &{1'b0, addr[ADDR_LSB-1:0], idx_full[31:IDX_W]};
`else
  // Upper address bits are dropped, so the array aliases modulo DEPTH words.
  assign in_range = 1'b1;
  logic unused_bits;
  assign unused_bits = &{1'b0, addr[ADDR_LSB-1:0], addr[31:ADDR_LSB+IDX_W],
                         idx_full[31:IDX_W]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && in_range) begin
      mem[idx] <= din;
    end
  end

  // No din bypass: a same-cycle write shows up only after the edge.
  always_comb begin
    dout = '0;
    if (!rst && in_range) begin
      dout = mem[idx];
    end
  end

endmodule

// File: tb/tb_rv_data_ram.sv
// Directed self-checking bench for rv_data_ram (honours DATA_RAM_BOUNDS_CHECK_EN).
module tb_rv_data_ram;

  logic        clk;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  rv_data_ram #(.DEPTH(256), .ADDR_LSB(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [31:0] a,
                             input logic [31:0] e);
    addr = a;
    exp_q.push_back(e);
    #1;
    check_eq(tag, dout, exp_q.pop_front());
  endtask

  initial begin
    rst  = 1'b1;
    we   = 1'b0;
    addr = 32'h0;
    din  = 32'h0;
    #1;
    read_expect("reset_dout", 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Load some data, then a 1 ns reset pulse between edges must clear it
    write_word(32'h10, 32'h5555AAAA);
    write_word(32'h3FC, 32'h77777777);
    read_expect("pre_pulse_3fc", 32'h3FC, 32'h77777777);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    read_expect("pulse_00", 32'h00, 32'h0);
    read_expect("pulse_10", 32'h10, 32'h0);
    read_expect("pulse_3fc", 32'h3FC, 32'h0);

    // Consecutive writes and readback
    write_word(32'h10, 32'hDEADBEEF);
    write_word(32'h20, 32'hCAFEBABE);
    read_expect("rb_10", 32'h10, 32'hDEADBEEF);
    read_expect("rb_20", 32'h20, 32'hCAFEBABE);
    read_expect("rb_00", 32'h00, 32'h0);

    // we low must not write
    @(negedge clk);
    addr = 32'h20;
    din  = 32'h0BADF00D;
    @(posedge clk);
    #1;
    read_expect("no_we_20", 32'h20, 32'hCAFEBABE);

    // Same-cycle write/read: old value before the edge, new after
    @(negedge clk);
    addr = 32'h10;
    din  = 32'h12345678;
    we   = 1'b1;
    #1;
    check_eq("same_before", dout, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    we = 1'b0;
    check_eq("same_after", dout, 32'h12345678);

    // Unaligned addresses hit the containing word
    write_word(32'h40, 32'hA5A5A5A5);
    read_expect("unal_41", 32'h41, 32'hA5A5A5A5);
    read_expect("unal_42", 32'h42, 32'hA5A5A5A5);
    read_expect("unal_43", 32'h43, 32'hA5A5A5A5);
    read_expect("unal_44", 32'h44, 32'h0);

    // Reset held across an edge with a pending write
    @(negedge clk);
    addr = 32'h20;
    din  = 32'hFFFFFFFF;
    we   = 1'b1;
    rst  = 1'b1;
    #1;
    check_eq("rst_high_dout", dout, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    we  = 1'b0;
    read_expect("rst_edge_20", 32'h20, 32'h0);
    read_expect("rst_edge_10", 32'h10, 32'h0);
    read_expect("rst_edge_40", 32'h40, 32'h0);

    // First write right after reset release, and the top word
    write_word(32'h08, 32'h0F0F0F0F);
    write_word(32'h3FC, 32'h89ABCDEF);
    read_expect("post_rst_08", 32'h08, 32'h0F0F0F0F);
    read_expect("top_3fc", 32'h3FC, 32'h89ABCDEF);

    // Upper address bits: alias or reject
    write_word(32'h400, 32'h11111111);
`ifdef DATA_RAM_BOUNDS_CHECK_EN
    read_expect("oob_000", 32'h000, 32'h0);
    read_expect("oob_400", 32'h400, 32'h0);
    read_expect("oob_7fc", 32'h7FC, 32'h0);
`else
    read_expect("wrap_000", 32'h000, 32'h11111111);
    read_expect("wrap_400", 32'h400, 32'h11111111);
    read_expect("wrap_7fc", 32'h7FC, 32'h89ABCDEF);
`endif
    read_expect("keep_08", 32'h08, 32'h0F0F0F0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
